multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/mips_ctrl_pkg.sv | 48 ++++
 rtl/mem_wait_timer.sv | 39 +++
 rtl/multicycle_controller.sv | 207 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control unit: opcodes, ALU op
// encodings, FSM state enumeration and trap cause.
package mips_ctrl_pkg;

    localparam int unsigned OP_RTYPE    = 0;
    localparam int unsigned OP_J        = 2;
    localparam int unsigned OP_BEQ      = 4;
    localparam int unsigned OP_BNE      = 5;
    localparam int unsigned OP_ADDI     = 8;
    localparam int unsigned OP_ADDIU    = 9;
    localparam int unsigned OP_ANDI     = 12;
    localparam int unsigned OP_ORI      = 13;
    localparam int unsigned OP_XORI     = 14;
    localparam int unsigned OP_SPECIAL2 = 28;
    localparam int unsigned OP_LW       = 35;
    localparam int unsigned OP_SW       = 43;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_XOR   = 3'b110;

    localparam int unsigned WAIT_W = 8;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_ALUWB  = 4'd7,
        S_EXEC_I = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_e;

    typedef enum logic {
        CAUSE_ILLEGAL = 1'b0,
        CAUSE_TIMEOUT = 1'b1
    } trap_cause_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles of an unanswered memory request; flags the cycle in which the
// count would reach the limit.
module mem_wait_timer
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned W = WAIT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // inc already excludes an ack cycle, so a same-cycle ack always wins.
    assign expired = inc && ((count_q + W'(1)) == limit);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: Moore outputs decoded from state, with the
// instruction/PC load strobes qualified by mem_ack during FETCH.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned OPW      = 6,
    parameter int unsigned ALUOPW   = 3,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OPW-1:0]    opcode,
    input  logic              mem_ack,
    input  logic              stall,
    output logic              mem_req,
    output logic              iord,
    output logic              ir_we,
    output logic              pc_we,
    output logic              sel1,
    output logic              sel2,
    output logic              sel3,
    output logic              we,
    output logic              we3,
    output logic              mrd,
    output logic              bre,
    output logic              brn,
    output logic              j,
    output logic              ofs,
    output logic [ALUOPW-1:0] op,
    output logic              instr_done,
    output logic              illegal,
    output logic              timeout
);

    state_e      state_q, state_d;
    trap_cause_e cause_q, cause_d;
    logic        boot_q;
    logic        fetch_busy_q, fetch_busy_d;
    logic        fetch_req;
    logic        wait_clr;
    logic        wait_inc;
    logic        wait_expired;

    function automatic logic [2:0] imm_alu_op(input logic [OPW-1:0] opc);
        case (opc)
            OPW'(OP_ANDI): return ALU_AND;
            OPW'(OP_ORI):  return ALU_OR;
            OPW'(OP_XORI): return ALU_XOR;
            default:       return ALU_ADD;
        endcase
    endfunction

    // The cycle after reset stays idle; once a fetch is outstanding stall no longer holds it off.
    assign fetch_req = !boot_q && (!stall || fetch_busy_q);
    assign wait_inc  = mem_req && !mem_ack;

    mem_wait_timer #(.W(WAIT_W)) u_wait (
        .clk     (clk),
        .rst     (rst),
        .clr     (wait_clr),
        .inc     (wait_inc),
        .limit   (WAIT_W'(MAX_WAIT)),
        .expired (wait_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            cause_q      <= CAUSE_ILLEGAL;
            fetch_busy_q <= 1'b0;
            boot_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cause_q      <= cause_d;
            fetch_busy_q <= fetch_busy_d;
            boot_q       <= 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        fetch_busy_d = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (fetch_req) begin
                    if (mem_ack) begin
                        state_d = S_DECODE;
                    end else if (wait_expired) begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_TIMEOUT;
                    end else begin
                        fetch_busy_d = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                case (opcode)
                    OPW'(OP_RTYPE), OPW'(OP_SPECIAL2): state_d = S_EXEC_R;
                    OPW'(OP_ADDI), OPW'(OP_ADDIU), OPW'(OP_ANDI),
                    OPW'(OP_ORI), OPW'(OP_XORI):       state_d = S_EXEC_I;
                    OPW'(OP_LW), OPW'(OP_SW):          state_d = S_MEMADR;
                    OPW'(OP_BEQ), OPW'(OP_BNE):        state_d = S_BRANCH;
                    OPW'(OP_J):                        state_d = S_JUMP;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode == OPW'(OP_SW)) ? S_MEMWR : S_MEMRD;
            S_MEMRD, S_MEMWR: begin
                if (mem_ack) begin
                    state_d = (state_q == S_MEMRD) ? S_MEMWB : S_FETCH;
                end else if (wait_expired) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_EXEC_R: state_d = S_ALUWB;
            S_EXEC_I: state_d = S_IWB;
            default:  state_d = S_FETCH;
        endcase
        wait_clr = (state_d != state_q) && (state_d inside {S_FETCH, S_MEMRD, S_MEMWR});
    end

    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        sel1       = 1'b0;
        sel2       = 1'b0;
        sel3       = 1'b0;
        we         = 1'b0;
        we3        = 1'b0;
        mrd        = 1'b0;
        bre        = 1'b0;
        brn        = 1'b0;
        j          = 1'b0;
        ofs        = 1'b0;
        op         = '0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (fetch_req) begin
                    mem_req = 1'b1;
                    mrd     = 1'b1;
                    ir_we   = mem_ack;
                    pc_we   = mem_ack;
                end
            end
            S_MEMADR: begin
                sel1 = 1'b1;
                op   = ALUOPW'(ALU_ADD);
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                mrd     = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                we3        = 1'b1;
                sel2       = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_req    = 1'b1;
                we         = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ack;
            end
            S_EXEC_R: op = ALUOPW'(ALU_FUNCT);
            S_ALUWB: begin
                we3        = 1'b1;
                sel3       = 1'b1;
                op         = ALUOPW'(ALU_FUNCT);
                instr_done = 1'b1;
            end
            S_EXEC_I, S_IWB: begin
                sel1       = 1'b1;
                op         = ALUOPW'(imm_alu_op(opcode));
                ofs        = (opcode == OPW'(OP_ADDI));
                we3        = (state_q == S_IWB);
                instr_done = (state_q == S_IWB);
            end
            S_BRANCH: begin
                op         = ALUOPW'(ALU_SUB);
                bre        = (opcode == OPW'(OP_BEQ));
                brn        = (opcode == OPW'(OP_BNE));
                instr_done = 1'b1;
            end
            S_JUMP: begin
                j          = 1'b1;
                instr_done = 1'b1;
            end
            S_TRAP: begin
                illegal = (cause_q == CAUSE_ILLEGAL);
                timeout = (cause_q == CAUSE_TIMEOUT);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed scoreboard bench for multicycle_controller (MAX_WAIT = 3).
module tb_multicycle_controller;

    localparam int NEVER = 1000;

    localparam logic [19:0] M_REQ  = 20'h80000;
    localparam logic [19:0] M_IORD = 20'h40000;
    localparam logic [19:0] M_IRWE = 20'h20000;
    localparam logic [19:0] M_PCWE = 20'h10000;
    localparam logic [19:0] M_SEL1 = 20'h08000;
    localparam logic [19:0] M_SEL2 = 20'h04000;
    localparam logic [19:0] M_SEL3 = 20'h02000;
    localparam logic [19:0] M_WE   = 20'h01000;
    localparam logic [19:0] M_WE3  = 20'h00800;
    localparam logic [19:0] M_MRD  = 20'h00400;
    localparam logic [19:0] M_BRE  = 20'h00200;
    localparam logic [19:0] M_BRN  = 20'h00100;
    localparam logic [19:0] M_J    = 20'h00080;
    localparam logic [19:0] M_OFS  = 20'h00040;
    localparam logic [19:0] M_DONE = 20'h00004;
    localparam logic [19:0] M_ILL  = 20'h00002;
    localparam logic [19:0] M_TO   = 20'h00001;
    localparam logic [19:0] F      = M_REQ | M_IRWE | M_PCWE | M_MRD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ack = 1'b0;
    logic       stall = 1'b0;
    logic       mem_req, iord, ir_we, pc_we, sel1, sel2, sel3, we, we3, mrd;
    logic       bre, brn, j, ofs, instr_done, illegal, timeout;
    logic [2:0] op;
    logic [19:0] outs;

    typedef struct {
        string       name;
        logic [19:0] ret;
        logic [19:0] acc;
        int          len;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          fetch_delay = 0;
    int          data_delay = 0;
    int          req_cnt = 0;
    int          mon_len = 0;
    logic [19:0] mon_acc = '0;

    multicycle_controller #(.OPW(6), .ALUOPW(3), .MAX_WAIT(3)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ack(mem_ack), .stall(stall),
        .mem_req(mem_req), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
        .sel1(sel1), .sel2(sel2), .sel3(sel3), .we(we), .we3(we3), .mrd(mrd),
        .bre(bre), .brn(brn), .j(j), .ofs(ofs), .op(op),
        .instr_done(instr_done), .illegal(illegal), .timeout(timeout)
    );

    always #5 clk = ~clk;

    assign outs = {mem_req, iord, ir_we, pc_we, sel1, sel2, sel3, we, we3, mrd,
                   bre, brn, j, ofs, op, instr_done, illegal, timeout};

    function automatic logic [19:0] opv(input logic [2:0] v);
        return {14'b0, v, 3'b0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Memory model: acks on request cycle (delay+1); delay picked by iord.
    always @(posedge clk) begin
        #2;
        if (rst) begin
            mem_ack = 1'b0;
            req_cnt = 0;
        end else begin
            if (mem_ack) begin
                mem_ack = 1'b0;
                req_cnt = 0;
            end
            if (mem_req) begin
                req_cnt++;
                if (req_cnt > (iord ? data_delay : fetch_delay)) mem_ack = 1'b1;
            end else begin
                req_cnt = 0;
            end
        end
    end

    // Monitor: on every retire/trap pulse pop one expectation and compare.
    always @(negedge clk) begin
        if (rst) begin
            mon_len = 0;
            mon_acc = '0;
        end else begin
            mon_len++;
            mon_acc = mon_acc | outs;
            if (illegal || timeout)
                chk("no_write_with_trap", {28'b0, we, we3, pc_we, ir_we}, 32'h0);
            if (instr_done || illegal || timeout) begin
                if (sb.size() == 0) begin
                    chk("unexpected_retire", {12'b0, outs}, 32'h0);
                end else begin
                    mon_e = sb.pop_front();
                    chk({mon_e.name, "_ret"}, {12'b0, outs}, {12'b0, mon_e.ret});
                    chk({mon_e.name, "_seen"}, {12'b0, mon_acc}, {12'b0, mon_e.acc});
                    chk({mon_e.name, "_cycles"}, mon_len, mon_e.len);
                end
                mon_len = 0;
                mon_acc = '0;
            end
        end
    end

    task automatic push_exp(input string nm, input logic [19:0] ret, input logic [19:0] acc,
                            input int len);
        exp_t e;
        e.name = nm;
        e.ret  = ret;
        e.acc  = acc;
        e.len  = len;
        sb.push_back(e);
    endtask

    task automatic wait_retire(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (instr_done || illegal || timeout) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_wait: no retire within 40 cycles", nm);
        end
    endtask

    task automatic run_instr(input string nm, input logic [5:0] opc, input int fd, input int dd,
                             input logic [19:0] ret, input logic [19:0] acc, input int len);
        push_exp(nm, ret, acc, len);
        @(posedge clk);
        #1;
        opcode      = opc;
        fetch_delay = fd;
        data_delay  = dd;
        wait_retire(nm);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst         = 1'b0;
        fetch_delay = 2;
        data_delay  = 2;
        @(negedge clk);
        chk("reset_outputs_zero", {12'b0, outs}, 32'h0);

        // lw: one post-reset idle cycle + FETCH(3) DECODE MEMADR MEMRD(3) MEMWB
        run_instr("lw", 6'd35, 2, 2, M_WE3 | M_SEL2 | M_DONE,
                  F | M_SEL1 | M_IORD | M_WE3 | M_SEL2 | M_DONE, 10);
        run_instr("rtype", 6'd0, 0, 0, M_WE3 | M_SEL3 | opv(3'b010) | M_DONE,
                  F | M_WE3 | M_SEL3 | opv(3'b010) | M_DONE, 4);
        run_instr("ori", 6'd13, 0, 0, M_SEL1 | M_WE3 | opv(3'b101) | M_DONE,
                  F | M_SEL1 | M_WE3 | opv(3'b101) | M_DONE, 4);
        run_instr("beq", 6'd4, 0, 0, M_BRE | opv(3'b001) | M_DONE,
                  F | M_BRE | opv(3'b001) | M_DONE, 3);
        run_instr("bne", 6'd5, 0, 0, M_BRN | opv(3'b001) | M_DONE,
                  F | M_BRN | opv(3'b001) | M_DONE, 3);

        // jump, with stall raised while the fetch is already outstanding
        push_exp("jump", M_J | M_DONE, F | M_J | M_DONE, 5);
        @(posedge clk);
        #1;
        opcode      = 6'd2;
        fetch_delay = 2;
        @(posedge clk);
        #1;
        stall = 1'b1;
        @(negedge clk);
        chk("stall_ignored_busy_c2", {31'b0, mem_req}, 32'h1);
        @(negedge clk);
        chk("stall_ignored_busy_c3", {31'b0, mem_req}, 32'h1);
        @(posedge clk);
        #1;
        stall = 1'b0;
        wait_retire("jump");

        run_instr("illegal", 6'd63, 0, 0, M_ILL, F | M_ILL, 3);
        run_instr("sw_timeout", 6'd43, 0, NEVER, M_TO, F | M_SEL1 | M_WE | M_IORD | M_TO, 7);
        run_instr("sw_ack_at_limit", 6'd43, 0, 2, M_REQ | M_WE | M_IORD | M_DONE,
                  F | M_SEL1 | M_WE | M_IORD | M_DONE, 6);
        run_instr("addi", 6'd8, 0, 0, M_SEL1 | M_OFS | M_WE3 | M_DONE,
                  F | M_SEL1 | M_OFS | M_WE3 | M_DONE, 4);

        // stall held five cycles in FETCH, then an opcode-28 R-type
        push_exp("stall_rtype", M_WE3 | M_SEL3 | opv(3'b010) | M_DONE,
                 F | M_WE3 | M_SEL3 | opv(3'b010) | M_DONE, 9);
        @(posedge clk);
        #1;
        opcode = 6'd28;
        stall  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("stall_mem_req_c%0d", k), {31'b0, mem_req}, 32'h0);
        end
        @(posedge clk);
        #1;
        stall = 1'b0;
        wait_retire("stall_rtype");

        // reset in the first MEMRD cycle of a lw that is never acknowledged
        @(posedge clk);
        #1;
        opcode      = 6'd35;
        fetch_delay = 0;
        data_delay  = NEVER;
        repeat (3) @(posedge clk);
        #1;
        chk("in_memrd_before_reset", {12'b0, outs & (M_REQ | M_IORD | M_MRD)},
            {12'b0, M_REQ | M_IORD | M_MRD});
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("after_reset_outputs_zero", {12'b0, outs}, 32'h0);
        run_instr("xori_after_reset", 6'd14, 0, 0, M_SEL1 | M_WE3 | opv(3'b110) | M_DONE,
                  F | M_SEL1 | M_WE3 | opv(3'b110) | M_DONE, 5);

        @(posedge clk);
        #1;
        stall = 1'b1;
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
